// File: rtl/clk_div_pkg.sv
// Shared types and defaults for divided-clock monitors and their benches.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    // Consecutive good periods before lock, and timeout as a multiple of DIV.
    localparam int DEF_LOCK_CNT     = 4;
    localparam int DEF_TIMEOUT_MULT = 4;

    // Expected length of one phase (high or low) for an even divide ratio.
    function automatic int half_period(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Two-flop sampler of a slow clock/level signal with rise/fall detection.
module clk_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;

    // Sample the input and keep one cycle of history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
        end
    end

    assign rise_o = s1_q & ~s2_q;
    assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low/period lengths of a divided clock and checks them
// against the expected divide ratio; reports lock, errors and stuck clock.
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int TIMEOUT  = DEF_TIMEOUT_MULT * DIV,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W:0]   period,
    output logic             period_vld,
    output logic             stuck
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_C     = CNT_W'(half_period(DIV));
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [GC_W-1:0]  LOCK_C  = GC_W'(LOCK_CNT);

    logic rise;
    logic fall;
    logic any_edge;
    logic timeout;
    logic period_done;
    logic good;
    logic [GC_W-1:0] good_cnt_inc;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] run_cnt_q,    run_cnt_d;
    logic [CNT_W-1:0] high_len_q,   high_len_d;
    logic             high_ok_q,    high_ok_d;
    logic [GC_W-1:0]  good_cnt_q,   good_cnt_d;
    logic             locked_q,     locked_d;
    logic             err_q,        err_d;
    logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;
    logic [CNT_W:0]   period_q,     period_d;
    logic             period_vld_q, period_vld_d;
    logic             stuck_q,      stuck_d;

    clk_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (clk_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign any_edge     = rise | fall;
    // An edge in the same cycle always pre-empts a timeout.
    assign timeout      = ~any_edge & (run_cnt_q == TO_M1);
    assign period_done  = rise & ((state_q == TRACK) | (state_q == LOCKED));
    assign good         = high_ok_q & (run_cnt_q == H_C);
    assign good_cnt_inc = good_cnt_q + GC_W'(1);

    // Next-state: run-length measurement, period reporting and lock FSM.
    always_comb begin
        state_d      = state_q;
        high_len_d   = high_len_q;
        high_ok_d    = high_ok_q;
        good_cnt_d   = good_cnt_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        err_d        = 1'b0;

        if (any_edge) begin
            run_cnt_d = CNT_W'(1);
        end else if (run_cnt_q == CNT_MAX) begin
            run_cnt_d = run_cnt_q;
        end else begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end

        if (fall) begin
            high_len_d = run_cnt_q;
            high_ok_d  = (run_cnt_q == H_C);
        end

        if (period_done) begin
            period_d     = {1'b0, high_len_q} + {1'b0, run_cnt_q};
            period_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A rise here belongs to a partial phase and is discarded.
                if (fall) state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end
            end
            TRACK: begin
                if (period_done) begin
                    if (good) begin
                        good_cnt_d = good_cnt_inc;
                        if (good_cnt_inc == LOCK_C) state_d = LOCKED;
                    end else begin
                        err_d      = 1'b1;
                        good_cnt_d = '0;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (period_done && !good) begin
                    err_d      = 1'b1;
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        locked_d  = (state_d == LOCKED);
        stuck_d   = (run_cnt_d >= TO_C);
        err_cnt_d = (err_d && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            run_cnt_q    <= '0;
            high_len_q   <= '0;
            high_ok_q    <= 1'b0;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            high_len_q   <= high_len_d;
            high_ok_q    <= high_ok_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            stuck_q      <= stuck_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: DIV=2 lock, DIV=4 error/timeout/reset,
// saturating error counter and reset release with the input high.
module tb_clk_div_monitor;
    import clk_div_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DIV=2 instance fed by a divide-by-2 ----------------
    logic        rst2;
    logic        clk_in2 = 1'b0;
    logic        locked2, err2, pv2, stuck2;
    logic [15:0] err_cnt2;
    logic [8:0]  period2;

    always @(posedge clk) clk_in2 <= ~clk_in2;

    clk_div_monitor #(.DIV(2)) u_d2 (
        .clk(clk), .rst(rst2), .clk_in(clk_in2), .locked(locked2), .err(err2),
        .err_cnt(err_cnt2), .period(period2), .period_vld(pv2), .stuck(stuck2)
    );

    // ---------------- DIV=4 instances, shared stimulus ----------------
    logic        rst4;
    logic        clk_in4;
    logic        locked4, err4, pv4, stuck4;
    logic [15:0] err_cnt4;
    logic [8:0]  period4;
    logic        locked_e, err_e, pv_e, stuck_e;
    logic [1:0]  err_cnt_e;
    logic [8:0]  period_e;

    clk_div_monitor #(.DIV(4), .TIMEOUT(16)) u_d4 (
        .clk(clk), .rst(rst4), .clk_in(clk_in4), .locked(locked4), .err(err4),
        .err_cnt(err_cnt4), .period(period4), .period_vld(pv4), .stuck(stuck4)
    );

    clk_div_monitor #(.DIV(4), .ERR_W(2)) u_e2 (
        .clk(clk), .rst(rst4), .clk_in(clk_in4), .locked(locked_e), .err(err_e),
        .err_cnt(err_cnt_e), .period(period_e), .period_vld(pv_e), .stuck(stuck_e)
    );

    // ---------------- monitors (sampled on the falling edge) ----------------
    int cyc = 0;
    int pv2_cnt = 0, bad_per2 = 0, gap_bad2 = 0, last_pv_cyc2 = 0;
    int lock_seen2 = 0, pv_at_lock2 = 0, lock_drop2 = 0;
    int pv4_cnt = 0, err4_n = 0, err_e_n = 0;
    int lock_at_err4 = 1;
    int last_period4 = 0;
    int period_hist[256];
    int lock_hist[256];
    int erre_hist[64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (pv2) begin
            pv2_cnt      <= pv2_cnt + 1;
            last_pv_cyc2 <= cyc;
            if (period2 != 9'd2) bad_per2 <= bad_per2 + 1;
            if (pv2_cnt != 0 && (cyc - last_pv_cyc2) != 2) gap_bad2 <= gap_bad2 + 1;
        end
        if (locked2 && lock_seen2 == 0) begin
            lock_seen2  <= 1;
            pv_at_lock2 <= pv2_cnt + (pv2 ? 1 : 0);
        end
        if (lock_seen2 != 0 && !locked2) lock_drop2 <= lock_drop2 + 1;

        if (pv4) begin
            pv4_cnt                          <= pv4_cnt + 1;
            period_hist[(pv4_cnt + 1) % 256] <= int'(period4);
            lock_hist[(pv4_cnt + 1) % 256]   <= int'(locked4);
            last_period4                     <= int'(period4);
        end
        if (err4) begin
            err4_n       <= err4_n + 1;
            lock_at_err4 <= int'(locked4);
        end
        if (err_e) begin
            err_e_n                  <= err_e_n + 1;
            erre_hist[err_e_n % 64]  <= int'(err_cnt_e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One period of clk_in4: hi cycles high then lo cycles low (called at posedge+1).
    task automatic drive(input int hi, input int lo);
        clk_in4 = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        clk_in4 = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    int n;
    int base;

    initial begin
        rst2    = 1'b1;
        rst4    = 1'b1;
        clk_in4 = 1'b0;

        // ---- 1: DIV=2 from divide-by-2, reset released at 17 ns ----
        #17 rst2 = 1'b0;
        chk("t1_reset_locked", 32'(locked2), 32'd0);
        chk("t1_reset_period", 32'(period2), 32'd0);
        repeat (1000) @(posedge clk);
        #1;
        chk("t1_pv_at_lock", 32'(pv_at_lock2), 32'd4);
        chk("t1_period_not_2", 32'(bad_per2), 32'd0);
        chk("t1_pv_gap", 32'(gap_bad2), 32'd0);
        chk("t1_many_pv", 32'(pv2_cnt > 400), 32'd1);
        chk("t1_locked", 32'(locked2), 32'd1);
        chk("t1_lock_drop", 32'(lock_drop2), 32'd0);
        chk("t1_err_cnt", 32'(err_cnt2), 32'd0);
        $display("t1 div2: pv=%0d locked=%0d err_cnt=%0d", pv2_cnt, locked2, err_cnt2);

        // ---- 2: DIV=4 lock, one bad 3/1 period, relock ----
        rst4 = 1'b0;
        repeat (7) drive(2, 2);
        drive(3, 1);
        repeat (5) drive(2, 2);
        chk("t2_lock_pv3", 32'(lock_hist[3]), 32'd0);
        chk("t2_lock_pv4", 32'(lock_hist[4]), 32'd1);
        chk("t2_period_good", 32'(period_hist[3]), 32'd4);
        chk("t2_period_bad", 32'(period_hist[7]), 32'd4);
        chk("t2_err_pulses", 32'(err4_n), 32'd1);
        chk("t2_err_cnt", 32'(err_cnt4), 32'd1);
        chk("t2_locked_at_err", 32'(lock_at_err4), 32'd0);
        chk("t2_lock_pv7", 32'(lock_hist[7]), 32'd0);
        chk("t2_relock_pv10", 32'(lock_hist[10]), 32'd0);
        chk("t2_relock_pv11", 32'(lock_hist[11]), 32'd1);
        $display("t2 bad period: err_cnt=%0d locked=%0d", err_cnt4, locked4);

        // ---- 3: hold clk_in low while locked -> timeout ----
        chk("t3_locked_before", 32'(locked4), 32'd1);
        clk_in4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clk_in4 = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (err4) break;
        end
        chk("t3_cycles_to_err", 32'(n), 32'd17);
        chk("t3_err", 32'(err4), 32'd1);
        chk("t3_stuck", 32'(stuck4), 32'd1);
        chk("t3_locked", 32'(locked4), 32'd0);
        chk("t3_state", 32'(u_d4.state_q), 32'(IDLE));
        @(posedge clk);
        #1;
        chk("t3_err_single", 32'(err4), 32'd0);
        chk("t3_stuck_held", 32'(stuck4), 32'd1);
        clk_in4 = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_stuck_pre_edge", 32'(stuck4), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_stuck_clear", 32'(stuck4), 32'd0);
        chk("t3_err_cnt", 32'(err_cnt4), 32'd2);
        $display("t3 timeout: cycles=%0d err_cnt=%0d", n, err_cnt4);

        // ---- 4: asynchronous reset between edges while locked ----
        repeat (8) drive(2, 2);
        chk("t4_locked_before", 32'(locked4), 32'd1);
        @(posedge clk);
        #2;
        rst4 = 1'b1;
        #1;
        chk("t4_locked", 32'(locked4), 32'd0);
        chk("t4_err_cnt", 32'(err_cnt4), 32'd0);
        chk("t4_period", 32'(period4), 32'd0);
        chk("t4_stuck", 32'(stuck4), 32'd0);
        chk("t4_err_cnt_e", 32'(err_cnt_e), 32'd0);
        #1 rst4 = 1'b0;
        $display("t4 async reset: locked=%0d period=%0d", locked4, period4);

        // ---- 5: ERR_W=2 saturation over 5 bad periods ----
        @(posedge clk);
        #1;
        base = err_e_n;
        repeat (2) drive(2, 2);
        repeat (5) drive(3, 1);
        repeat (2) drive(2, 2);
        chk("t5_err_pulses", 32'(err_e_n - base), 32'd5);
        chk("t5_cnt_1", 32'(erre_hist[(base + 0) % 64]), 32'd1);
        chk("t5_cnt_2", 32'(erre_hist[(base + 1) % 64]), 32'd2);
        chk("t5_cnt_3", 32'(erre_hist[(base + 2) % 64]), 32'd3);
        chk("t5_cnt_4", 32'(erre_hist[(base + 3) % 64]), 32'd3);
        chk("t5_cnt_5", 32'(erre_hist[(base + 4) % 64]), 32'd3);
        chk("t5_err_cnt_e", 32'(err_cnt_e), 32'd3);
        chk("t5_err_cnt_wide", 32'(err_cnt4), 32'd5);
        $display("t5 saturation: err_cnt_e=%0d err_cnt4=%0d", err_cnt_e, err_cnt4);

        // ---- 6: reset released with clk_in high ----
        clk_in4 = 1'b1;
        rst4    = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst4 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        base    = pv4_cnt;
        clk_in4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(2, 2);
        chk("t6_no_pv_yet", 32'(pv4_cnt - base), 32'd0);
        drive(2, 2);
        chk("t6_one_pv", 32'(pv4_cnt - base), 32'd1);
        chk("t6_first_period", 32'(last_period4), 32'd4);
        $display("t6 release high: pv=%0d period=%0d", pv4_cnt - base, last_period4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
